// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle RISC control path.
// Holds the FSM state encodings, instruction opcode/op field values,
// memory command codes, write-back mux codes, ALU op codes and the
// instruction-class flag set produced by the decoder.
package cpu_defs_pkg;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam int STATE_W = 5;
  localparam logic [STATE_W-1:0] S_RST     = 5'd0;
  localparam logic [STATE_W-1:0] S_IF1     = 5'd1;
  localparam logic [STATE_W-1:0] S_IF2     = 5'd2;
  localparam logic [STATE_W-1:0] S_UPD_PC  = 5'd3;
  localparam logic [STATE_W-1:0] S_DECODE  = 5'd4;
  localparam logic [STATE_W-1:0] S_GET_A   = 5'd5;
  localparam logic [STATE_W-1:0] S_GET_B   = 5'd6;
  localparam logic [STATE_W-1:0] S_EXEC    = 5'd7;
  localparam logic [STATE_W-1:0] S_WB      = 5'd8;
  localparam logic [STATE_W-1:0] S_WR_IMM  = 5'd9;
  localparam logic [STATE_W-1:0] S_ADDR    = 5'd10;
  localparam logic [STATE_W-1:0] S_LD_ADDR = 5'd11;
  localparam logic [STATE_W-1:0] S_MEM_RD  = 5'd12;
  localparam logic [STATE_W-1:0] S_LDR_WB  = 5'd13;
  localparam logic [STATE_W-1:0] S_STR_GET = 5'd14;
  localparam logic [STATE_W-1:0] S_STR_C   = 5'd15;
  localparam logic [STATE_W-1:0] S_STR_MEM = 5'd16;
  localparam logic [STATE_W-1:0] S_HALT    = 5'd17;

  // opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field IR[12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    VSEL_MDATA  = 2'b00,
    VSEL_SXIMM8 = 2'b01,
    VSEL_PC     = 2'b10,
    VSEL_C      = 2'b11
  } vsel_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  typedef struct packed {
    logic mov_imm;
    logic mov_reg;
    logic alu;
    logic cmp;
    logic mvn;
    logic ldr;
    logic str;
    logic halt;
  } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   ir      in  16  instruction register
//   op      out 2   IR[12:11]
//   rn/rd/rm out 3  register fields IR[10:8], IR[7:5], IR[2:0]
//   sh      out 2   shift field IR[4:3]
//   sximm8  out 16  sign-extended IR[7:0]
//   sximm5  out 16  sign-extended IR[4:0]
//   cls     out     instruction-class flags
module instr_decoder
  import cpu_defs_pkg::*;
(
  input  logic [15:0]  ir,
  output logic [1:0]   op,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [2:0]   rm,
  output logic [1:0]   sh,
  output logic [15:0]  sximm8,
  output logic [15:0]  sximm5,
  output instr_class_t cls
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // Encodings that match none of these flags execute as NOPs.
  always_comb begin
    cls         = '0;
    cls.mov_imm = (opcode == OPC_MOV)  && (op == OP_MOV_IMM);
    cls.mov_reg = (opcode == OPC_MOV)  && (op == OP_MOV_REG);
    cls.alu     = (opcode == OPC_ALU);
    cls.cmp     = (opcode == OPC_ALU)  && (op == OP_CMP);
    cls.mvn     = (opcode == OPC_ALU)  && (op == OP_MVN);
    cls.ldr     = (opcode == OPC_LDR)  && (op == OP_MEM);
    cls.str     = (opcode == OPC_STR)  && (op == OP_MEM);
    cls.halt    = (opcode == OPC_HALT) && (op == OP_MEM);
  end

endmodule

// File: rtl/fetch_control_fsm.sv
// Multicycle fetch/decode/control sequencer for the 16-bit, 8-register core.
// Owns PC, IR and the data-address register; all datapath strobes are Moore
// outputs decoded from the current state and the IR fields.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mdata               memory read data (instruction source in fetch)
//   datapath_out        ALU result C; low PC_W bits form the load/store address
//   mem_cmd, mem_addr   memory port command and address
//   PC                  program counter
//   vsel, write, writenum, readnum   register-file controls
//   loada/loadb/loadc/loads, asel, bsel, shift, aluop   datapath controls
//   sximm8, sximm5      sign-extended immediates
//   halted              high in HALT
module fetch_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     mdata,
  input  logic [15:0]     datapath_out,
  output logic [1:0]      mem_cmd,
  output logic [PC_W-1:0] mem_addr,
  output logic [PC_W-1:0] PC,
  output logic [1:0]      vsel,
  output logic            write,
  output logic [2:0]      writenum,
  output logic [2:0]      readnum,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic            asel,
  output logic            bsel,
  output logic [1:0]      shift,
  output logic [1:0]      aluop,
  output logic [15:0]     sximm8,
  output logic [15:0]     sximm5,
  output logic            halted
);

  logic [STATE_W-1:0] state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [15:0]        ir_reg, ir_next;
  logic [PC_W-1:0]    daddr_reg, daddr_next;

  logic [1:0]   op;
  logic [2:0]   rn, rd, rm;
  logic [1:0]   sh;
  instr_class_t cls;

  instr_decoder u_dec (
    .ir     (ir_reg),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm8 (sximm8),
    .sximm5 (sximm5),
    .cls    (cls)
  );

  // Only the low PC_W bits of C address memory.
  generate
    if (PC_W < 16) begin : g_dp_hi
      logic unused_dp_hi;
      assign unused_dp_hi = ^datapath_out[15:PC_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RST;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      daddr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      daddr_reg <= daddr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    daddr_next = daddr_reg;
    case (state_reg)
      S_RST:    state_next = S_IF1;
      S_IF1:    state_next = S_IF2;
      S_IF2: begin
        ir_next    = mdata;
        state_next = S_UPD_PC;
      end
      S_UPD_PC: begin
        // natural wrap from all-ones to zero
        pc_next    = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (cls.mov_imm)                  state_next = S_WR_IMM;
        else if (cls.mov_reg)             state_next = S_GET_B;
        else if (cls.alu || cls.ldr || cls.str) state_next = S_GET_A;
        else if (cls.halt)                state_next = S_HALT;
        else                              state_next = S_IF1;
      end
      S_GET_A:   state_next = (cls.ldr || cls.str) ? S_ADDR : S_GET_B;
      S_GET_B:   state_next = S_EXEC;
      S_EXEC:    state_next = cls.cmp ? S_IF1 : S_WB;
      S_WB:      state_next = S_IF1;
      S_WR_IMM:  state_next = S_IF1;
      S_ADDR:    state_next = S_LD_ADDR;
      S_LD_ADDR: begin
        daddr_next = datapath_out[PC_W-1:0];
        state_next = cls.ldr ? S_MEM_RD : S_STR_GET;
      end
      S_MEM_RD:  state_next = S_LDR_WB;
      S_LDR_WB:  state_next = S_IF1;
      S_STR_GET: state_next = S_STR_C;
      S_STR_C:   state_next = S_STR_MEM;
      S_STR_MEM: state_next = S_IF1;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_RST;
    endcase
  end

  assign PC       = pc_reg;
  assign mem_addr = (state_reg == S_IF1 || state_reg == S_IF2) ? pc_reg : daddr_reg;

  always_comb begin
    mem_cmd  = MEM_NONE;
    vsel     = VSEL_MDATA;
    write    = 1'b0;
    writenum = 3'd0;
    readnum  = 3'd0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    aluop    = ALU_ADD;
    halted   = 1'b0;
    case (state_reg)
      S_IF1, S_IF2: mem_cmd = MEM_READ;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = sh;
        aluop = cls.mov_reg ? ALU_ADD : op;
        // A forced to zero: MOV passes B through, MVN ignores A
        asel  = cls.mov_reg || cls.mvn;
        loads = cls.cmp;
        loadc = !cls.cmp;
      end
      S_WB: begin
        vsel     = VSEL_C;
        write    = 1'b1;
        writenum = rd;
      end
      S_WR_IMM: begin
        vsel     = VSEL_SXIMM8;
        write    = 1'b1;
        writenum = rn;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_RD: mem_cmd = MEM_READ;
      S_LDR_WB: begin
        mem_cmd  = MEM_READ;
        vsel     = VSEL_MDATA;
        write    = 1'b1;
        writenum = rd;
      end
      S_STR_GET: begin
        readnum = rd;
        loadb   = 1'b1;
      end
      S_STR_C: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_STR_MEM: mem_cmd = MEM_WRITE;
      S_HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_control_fsm.sv
module tb_fetch_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mdata;
  logic [15:0] datapath_out = 16'h0000;
  logic [1:0]  mem_cmd;
  logic [7:0]  mem_addr;
  logic [7:0]  PC;
  logic [1:0]  vsel;
  logic        write;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic [15:0] sximm8, sximm5;
  logic        halted;

  logic [15:0] mem [256];
  assign mdata = mem[mem_addr];

  always #5 clk = ~clk;

  fetch_control_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mdata        (mdata),
    .datapath_out (datapath_out),
    .mem_cmd      (mem_cmd),
    .mem_addr     (mem_addr),
    .PC           (PC),
    .vsel         (vsel),
    .write        (write),
    .writenum     (writenum),
    .readnum      (readnum),
    .loada        (loada),
    .loadb        (loadb),
    .loadc        (loadc),
    .loads        (loads),
    .asel         (asel),
    .bsel         (bsel),
    .shift        (shift),
    .aluop        (aluop),
    .sximm8       (sximm8),
    .sximm5       (sximm5),
    .halted       (halted)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // strobes packed for compact "all quiet" checks
  function automatic logic [6:0] strobes();
    return {loada, loadb, loadc, loads, asel, bsel, write};
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [15:0] dp;
    int          cycles;
    int          wr_cnt;
    logic [2:0]  wnum;
    logic [1:0]  vsel;
    logic [15:0] imm8;
    int          memw_cnt;
    logic [7:0]  memw_addr;
    int          loadc_cnt;
    int          loads_cnt;
    int          asel_cnt;
  } vec_t;

  vec_t vecs[12];

  // results of one run_instr call
  int          r_cycles, r_wr, r_memw, r_loadc, r_loads, r_asel;
  logic [2:0]  r_wnum;
  logic [1:0]  r_vsel;
  logic [15:0] r_imm8;
  logic [7:0]  r_memw_addr;
  logic        r_done;

  task automatic load_prog(input logic [15:0] instr);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = instr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs mem[0] from reset until the next fetch of address 1 begins.
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] dp);
    int cyc;
    load_prog(instr);
    datapath_out = dp;
    do_reset();
    cyc = 0; r_done = 1'b0;
    r_wr = 0; r_memw = 0; r_loadc = 0; r_loads = 0; r_asel = 0;
    r_wnum = '0; r_vsel = '0; r_imm8 = '0; r_memw_addr = '0;
    for (int k = 0; k < 40 && !r_done; k++) begin
      @(negedge clk);
      if (cyc > 0 && mem_cmd == 2'b01 && PC == 8'd1 && mem_addr == 8'd1) begin
        r_done = 1'b1;
      end else begin
        if (write) begin
          r_wr++; r_wnum = writenum; r_vsel = vsel; r_imm8 = sximm8;
        end
        if (mem_cmd == 2'b10) begin
          r_memw++; r_memw_addr = mem_addr;
        end
        if (loadc) r_loadc++;
        if (loads) r_loads++;
        if (asel)  r_asel++;
        cyc++;
      end
    end
    r_cycles = cyc;
  endtask

  initial begin
    //          instr     dp        cyc wr wn    vsel   imm8      mw ma     lc ls as
    vecs[0]  = '{16'hD205, 16'h0000, 5,  1, 3'd2, 2'b01, 16'h0005, 0, 8'h00, 0, 0, 0};
    vecs[1]  = '{16'hD1FF, 16'h0000, 5,  1, 3'd1, 2'b01, 16'hFFFF, 0, 8'h00, 0, 0, 0};
    vecs[2]  = '{16'hA161, 16'h000A, 8,  1, 3'd3, 2'b11, 16'h0061, 0, 8'h00, 1, 0, 0};
    vecs[3]  = '{16'hA900, 16'h0000, 7,  0, 3'd0, 2'b00, 16'h0000, 0, 8'h00, 0, 1, 0};
    vecs[4]  = '{16'h6044, 16'h0014, 9,  1, 3'd2, 2'b00, 16'h0044, 0, 8'h00, 1, 0, 0};
    vecs[5]  = '{16'h8044, 16'h0030, 10, 0, 3'd0, 2'b00, 16'h0000, 1, 8'h30, 2, 0, 1};
    vecs[6]  = '{16'hC041, 16'h0000, 7,  1, 3'd2, 2'b11, 16'h0041, 0, 8'h00, 1, 0, 1};
    vecs[7]  = '{16'hB861, 16'h0000, 8,  1, 3'd3, 2'b11, 16'h0061, 0, 8'h00, 1, 0, 1};
    vecs[8]  = '{16'hB061, 16'h0000, 8,  1, 3'd3, 2'b11, 16'h0061, 0, 8'h00, 1, 0, 0};
    vecs[9]  = '{16'h0000, 16'h0000, 4,  0, 3'd0, 2'b00, 16'h0000, 0, 8'h00, 0, 0, 0};
    vecs[10] = '{16'hC800, 16'h0000, 4,  0, 3'd0, 2'b00, 16'h0000, 0, 8'h00, 0, 0, 0};
    vecs[11] = '{16'hE800, 16'h0000, 4,  0, 3'd0, 2'b00, 16'h0000, 0, 8'h00, 0, 0, 0};

    // reset state with no clock edge seen yet
    load_prog(16'h0000);
    #3;
    chk("reset_strobes", {25'd0, strobes()}, 32'd0);
    chk("reset_mem_cmd", {30'd0, mem_cmd}, 32'd0);
    chk("reset_pc", {24'd0, PC}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].instr, vecs[i].dp);
      $display("vec %0d instr=%h cycles=%0d writes=%0d memw=%0d", i, vecs[i].instr, r_cycles, r_wr, r_memw);
      chk($sformatf("v%0d_done", i), {31'd0, r_done}, 32'd1);
      chk($sformatf("v%0d_cycles", i), r_cycles, vecs[i].cycles);
      chk($sformatf("v%0d_write_cnt", i), r_wr, vecs[i].wr_cnt);
      if (vecs[i].wr_cnt > 0) begin
        chk($sformatf("v%0d_writenum", i), {29'd0, r_wnum}, {29'd0, vecs[i].wnum});
        chk($sformatf("v%0d_vsel", i), {30'd0, r_vsel}, {30'd0, vecs[i].vsel});
        chk($sformatf("v%0d_sximm8", i), {16'd0, r_imm8}, {16'd0, vecs[i].imm8});
      end
      chk($sformatf("v%0d_memw_cnt", i), r_memw, vecs[i].memw_cnt);
      if (vecs[i].memw_cnt > 0)
        chk($sformatf("v%0d_memw_addr", i), {24'd0, r_memw_addr}, {24'd0, vecs[i].memw_addr});
      chk($sformatf("v%0d_loadc_cnt", i), r_loadc, vecs[i].loadc_cnt);
      chk($sformatf("v%0d_loads_cnt", i), r_loads, vecs[i].loads_cnt);
      chk($sformatf("v%0d_asel_cnt", i), r_asel, vecs[i].asel_cnt);
    end

    // ADD R3,R1,R1 cycle by cycle, then abort in WB
    load_prog(16'hA161);
    datapath_out = 16'h000A;
    do_reset();
    repeat (5) @(negedge clk);  // GET_A
    chk("add_geta_loada", {31'd0, loada}, 32'd1);
    chk("add_geta_readnum", {29'd0, readnum}, 32'd1);
    @(negedge clk);             // GET_B
    chk("add_getb_loadb", {31'd0, loadb}, 32'd1);
    chk("add_getb_readnum", {29'd0, readnum}, 32'd1);
    @(negedge clk);             // EXEC
    chk("add_exec_strobes", {25'd0, strobes()}, {25'd0, 7'b0010000});
    chk("add_exec_aluop", {30'd0, aluop}, 32'd0);
    @(negedge clk);             // WB
    chk("add_wb_write", {31'd0, write}, 32'd1);
    chk("add_wb_vsel", {30'd0, vsel}, 32'd3);
    chk("add_wb_writenum", {29'd0, writenum}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wb_write", {31'd0, write}, 32'd0);
    chk("abort_wb_pc", {24'd0, PC}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LDR R2,[R0,#4] address path
    load_prog(16'h6044);
    datapath_out = 16'h0014;
    do_reset();
    repeat (6) @(negedge clk);  // ADDR
    chk("ldr_addr_bsel_loadc", {30'd0, bsel, loadc}, 32'd3);
    chk("ldr_addr_sximm5", {16'd0, sximm5}, 32'h0004);
    repeat (2) @(negedge clk);  // MEM_RD
    chk("ldr_memrd_addr", {24'd0, mem_addr}, 32'h14);
    chk("ldr_memrd_cmd", {30'd0, mem_cmd}, 32'd1);
    @(negedge clk);             // LDR_WB
    chk("ldr_wb_write_vsel", {29'd0, write, vsel}, {29'd0, 3'b100});
    chk("ldr_wb_writenum", {29'd0, writenum}, 32'd2);
    chk("ldr_wb_cmd", {30'd0, mem_cmd}, 32'd1);

    // HALT at 255: PC wraps, then quiet until reset
    begin
      int bad;
      load_prog(16'h0000);
      mem[255] = 16'hE000;
      datapath_out = 16'h0000;
      do_reset();
      for (int k = 0; k < 1200 && !halted; k++) @(negedge clk);
      chk("halt_reached", {31'd0, halted}, 32'd1);
      chk("halt_pc_wrapped", {24'd0, PC}, 32'd0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (strobes() != 7'd0 || mem_cmd != 2'b00 || halted != 1'b1) bad++;
      end
      chk("halt_quiet_20", bad, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_halted", {31'd0, halted}, 32'd0);
      chk("async_rst_pc", {24'd0, PC}, 32'd0);
      chk("async_rst_mem_cmd", {30'd0, mem_cmd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);           // IF1 after release
      chk("refetch_addr", {24'd0, mem_addr}, 32'h00);
      chk("refetch_cmd", {30'd0, mem_cmd}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_control_fsm.md
Name: fetch_control_fsm

Overview:
- Multicycle fetch/decode/control sequencer for the 16-bit, 8-register RISC core.
- Owns the PC, the instruction register (IR) and the data-address register.
- Drives every datapath strobe, including the register-file write-back controls (vsel, write, writenum).
- Sits directly upstream of the register-file write stage and the memory port.

Parameters:
- PC_W, 8, width of PC, mem_addr and the data-address register.
- RESET_PC, 8'h00, value loaded into PC on reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mdata  in  16  memory read data; instruction source during fetch
- datapath_out  in  16  ALU result register C; low PC_W bits give the LDR/STR address
- mem_cmd  out  2  memory command: 00 NONE, 01 READ, 10 WRITE
- mem_addr  out  PC_W  PC while in IF1/IF2, else data-address register
- PC  out  PC_W  current program counter
- vsel  out  2  write-back mux select: 00 mdata, 01 sximm8, 10 PC, 11 C
- write  out  1  register-file write enable
- writenum  out  3  destination register
- readnum  out  3  source register read index
- loada, loadb, loadc, loads  out  1 each  A/B/C/status register loads
- asel, bsel  out  1 each  asel=1 forces A to 0; bsel=1 selects sximm5 for B
- shift  out  2  shifter control
- aluop  out  2  00 ADD, 01 CMP(SUB), 10 AND, 11 MVN
- sximm8, sximm5  out  16 each  sign-extended IR[7:0] and IR[4:0]
- halted  out  1  high while in HALT

Behaviour:
- IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Moore outputs: all strobes are decoded from state plus IR fields. Any strobe not listed for a state is 0; mem_cmd defaults to NONE.
- Reset (async, rst_n=0):
  - state=RST, PC=RESET_PC, IR=0, data-address register=0.
  - All strobes 0, mem_cmd=NONE, halted=0, all effective immediately with no clock edge.
- RST -> IF1.
- IF1: mem_addr=PC, mem_cmd=READ -> IF2.
- IF2: mem_cmd=READ; IR<=mdata at the clock edge -> UPD_PC.
- UPD_PC: PC<=PC+1 modulo 2^PC_W (max wraps to 0) -> DECODE.
- DECODE transitions:
  - 110/10 MOV imm -> WR_IMM
  - 110/00 MOV reg -> GET_B
  - 101/xx ALU op -> GET_A
  - 011/00 LDR -> GET_A
  - 100/00 STR -> GET_A
  - 111/00 HALT -> HALT
  - any other encoding -> IF1 (NOP; no strobes asserted)
- GET_A: readnum=Rn, loada=1. LDR/STR -> ADDR; otherwise -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> EXEC.
- EXEC:
  - shift=sh, aluop=op; MOV reg forces aluop=00.
  - asel=1 for MOV reg and MVN; bsel=0.
  - CMP: loads=1, loadc=0 -> IF1 (no register write).
  - All other ops: loadc=1 -> WB.
- WB: vsel=11, write=1, writenum=Rd -> IF1.
- WR_IMM: vsel=01, write=1, writenum=Rn -> IF1.
- ADDR: asel=0, bsel=1, aluop=00, shift=00, loadc=1 -> LD_ADDR.
- LD_ADDR: data-address register<=datapath_out[PC_W-1:0]. LDR -> MEM_RD; STR -> STR_GET.
- MEM_RD: mem_cmd=READ, mem_addr=data-address -> LDR_WB.
- LDR_WB: mem_cmd=READ held, vsel=00, write=1, writenum=Rd -> IF1.
- STR_GET: readnum=Rd, loadb=1 -> STR_C.
- STR_C: asel=1, bsel=0, aluop=00, shift=00, loadc=1 -> STR_MEM.
- STR_MEM: mem_cmd=WRITE, mem_addr=data-address -> IF1.
- HALT: halted=1, no strobes; held until rst_n is asserted.
- write is asserted in at most one cycle per instruction. It is never asserted for CMP, STR, HALT or NOP.
- Sign extension: sximm8 = {8{IR[7]},IR[7:0]}; sximm5 = {11{IR[4]},IR[4:0]}.
- rst_n asserted in any state (including WB and STR_MEM) aborts the instruction immediately: no write, no memory write. Fetch restarts from RESET_PC.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - state enum
  - opcode/op constants
  - mem_cmd codes (NONE/READ/WRITE)
  - vsel codes (MDATA/SXIMM8/PC/C)
  - aluop codes
- Sub-module instr_decoder (combinational): IR -> opcode, op, Rn, Rd, Rm, sh, sximm8, sximm5, plus an instruction-class flag set.
- The FSM, PC, IR and data-address register stay in fetch_control_fsm.

Test Plan:
- MOV imm: reset, memory[0]=16'hD205 (MOV R2,#5) -> write=1 for exactly one cycle in WR_IMM, vsel=01, writenum=2, sximm8=16'h0005; PC=1 afterwards.
- MOV imm negative: memory[0]=16'hD1FF -> sximm8=16'hFFFF.
- ADD: memory[0]=16'hA161 (ADD R3,R1,R1 with sh=00), datapath_out=16'h000A -> loada (readnum=1), then loadb (readnum=1), then loadc with aluop=00, then WB: vsel=11, writenum=3.
- CMP: 16'hA900 -> loads=1; write never asserted; returns to IF1 after 7 cycles total.
- LDR: 16'h6044 (LDR R2,[R0,#4]), datapath_out=16'h0014 at LD_ADDR -> MEM_RD mem_addr=8'h14, mem_cmd=01; LDR_WB vsel=00, writenum=2.
- STR: 16'h8044 with datapath_out=16'h0030 at LD_ADDR -> mem_cmd=10 at mem_addr=8'h30 for one cycle; write stays 0.
- HALT/reset/wrap: HALT at PC=255 -> halted=1 with PC=0 (wrapped), no strobes for 20 cycles. Then drop rst_n mid-cycle -> outputs clear asynchronously; after release the fetch mem_addr is 8'h00.
